// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-port register-file arbiter: FSM encoding
// and port index constants.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Two-input round-robin selector: a lone request wins outright, a tie goes
// to the port named by prio.
module reg_arb_rr_pick
    import reg_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = PORT0;
        if (req0 && req1) begin
            gnt_idx = prio;
        end else if (req1) begin
            gnt_idx = PORT1;
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares one register-file port between two requesters: round-robin grant,
// one transaction in flight, read timeout and per-port completion ack.
module reg_file_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Wr_D,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                state_reg, state_next;
    logic                  prio_reg;
    logic                  owner_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [7:0]            cnt_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  rsp_err_reg;
    logic                  gnt_valid;
    logic                  gnt_idx;
    logic                  timeout_hit;

    reg_arb_rr_pick u_pick (
        .req0      (p0_req),
        .req1      (p1_req),
        .prio      (prio_reg),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign timeout_hit = (cnt_reg == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt_valid) state_next = ISSUE;
            ISSUE:   state_next = we_reg ? DONE : WAIT;
            WAIT:    if (RdData_Valid || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured only at grant; the latched address and
    // data double as the registered register-file bus, so they hold the
    // last issued values between transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg     <= PORT0;
            owner_reg    <= PORT0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_reg <= gnt_idx;
                        we_reg    <= (gnt_idx == PORT1) ? p1_we    : p0_we;
                        addr_reg  <= (gnt_idx == PORT1) ? p1_addr  : p0_addr;
                        wdata_reg <= (gnt_idx == PORT1) ? p1_wdata : p0_wdata;
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                    if (we_reg) rsp_err_reg <= 1'b0;
                end
                WAIT: begin
                    // Valid data takes precedence over a coincident timeout.
                    if (RdData_Valid) begin
                        rsp_data_reg <= RdData;
                        rsp_err_reg  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_reg <= '0;
                        rsp_err_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: prio_reg <= ~owner_reg;
                default: ;
            endcase
        end
    end

    assign WrEn     = (state_reg == ISSUE) &&  we_reg;
    assign RdEn     = (state_reg == ISSUE) && !we_reg;
    assign Address  = addr_reg;
    assign Wr_D     = wdata_reg;
    assign p0_ack   = (state_reg == DONE) && (owner_reg == PORT0);
    assign p1_ack   = (state_reg == DONE) && (owner_reg == PORT1);
    assign busy     = (state_reg != IDLE);
    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter; one task per scenario, inline checks.
module tb_reg_file_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p1_ack, rsp_err, busy, WrEn, RdEn;
    logic [DW-1:0] rsp_data, Wr_D;
    logic [AW-1:0] Address;
    logic [DW-1:0] RdData = '0;
    logic          RdData_Valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .Wr_D(Wr_D),
        .RdData(RdData), .RdData_Valid(RdData_Valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++; if ({WrEn, RdEn, p0_ack, p1_ack, rsp_err, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {WrEn, RdEn, p0_ack, p1_ack, rsp_err, busy}); end
        n_checks++; if (Address !== '0 || Wr_D !== '0) begin n_fail++; $display("FAIL reset_bus: got addr %h wd %h want 0 0", Address, Wr_D); end
        n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp: got %h want 00", rsp_data); end
        rst = 1'b0;
        step();
        $display("reset: outputs idle");
    endtask

    task automatic test_write_p0();
        p0_req = 1; p0_we = 1; p0_addr = 4'd3; p0_wdata = 8'h5A;
        step();
        p0_addr = 4'd9; p0_wdata = 8'hFF;
        n_checks++; if ({WrEn, RdEn} !== 2'b10) begin n_fail++; $display("FAIL wr_strobe: got WrEn/RdEn %b want 10", {WrEn, RdEn}); end
        n_checks++; if (Address !== 4'd3 || Wr_D !== 8'h5A) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 3/5a", Address, Wr_D); end
        n_checks++; if (p0_ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: got %b want 0", p0_ack); end
        step();
        n_checks++; if ({p0_ack, p1_ack, WrEn} !== 3'b100) begin n_fail++; $display("FAIL wr_ack: got p0/p1/WrEn %b want 100", {p0_ack, p1_ack, WrEn}); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", rsp_err); end
        p0_req = 0;
        step();
        n_checks++; if ({busy, p0_ack, Address} !== {1'b0, 1'b0, 4'd3}) begin n_fail++; $display("FAIL wr_after: got busy %b ack %b addr %h want 0 0 3", busy, p0_ack, Address); end
        $display("txn: p0 write addr 3 data 5a");
    endtask

    task automatic test_read_p1();
        p1_req = 1; p1_we = 0; p1_addr = 4'd7;
        step();
        n_checks++; if ({WrEn, RdEn} !== 2'b01 || Address !== 4'd7) begin n_fail++; $display("FAIL rd_strobe: got WrEn/RdEn %b addr %h want 01 7", {WrEn, RdEn}, Address); end
        step();
        RdData = 8'hC3; RdData_Valid = 1;
        n_checks++; if (p1_ack !== 1'b0 || RdEn !== 1'b0) begin n_fail++; $display("FAIL rd_wait: got ack %b RdEn %b want 0 0", p1_ack, RdEn); end
        step();
        RdData_Valid = 0; RdData = 8'h00;
        n_checks++; if ({p0_ack, p1_ack} !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got p0/p1 %b want 01", {p0_ack, p1_ack}); end
        n_checks++; if (rsp_data !== 8'hC3 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %h err %b want c3 0", rsp_data, rsp_err); end
        p1_req = 0;
        step();
        $display("txn: p1 read addr 7 -> c3");
    endtask

    task automatic test_timeout();
        int cyc = 0;
        bit got = 0;
        p0_req = 1; p0_we = 0; p0_addr = 4'd2;
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (p0_ack) begin got = 1; cyc = k; end
        end
        n_checks++; if (cyc !== TO + 2) begin n_fail++; $display("FAIL to_latency: got %0d cycles want %0d", cyc, TO + 2); end
        n_checks++; if (rsp_err !== 1'b1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL to_rsp: got %h err %b want 00 1", rsp_data, rsp_err); end
        p0_req = 0;
        step();
        $display("txn: p0 read addr 2 timed out after %0d cycles", cyc);
        p0_req = 1; p0_addr = 4'd4;
        step(); step();
        RdData = 8'h11; RdData_Valid = 1;
        step();
        RdData_Valid = 0; RdData = 8'h00;
        n_checks++; if (p0_ack !== 1'b1 || rsp_data !== 8'h11 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL to_recover: got ack %b %h err %b want 1 11 0", p0_ack, rsp_data, rsp_err); end
        p0_req = 0;
        step();
        n_checks++; if (rsp_data !== 8'h11) begin n_fail++; $display("FAIL rsp_hold: got %h want 11", rsp_data); end
        $display("txn: p0 read addr 4 -> 11");
    endtask

    task automatic test_valid_edges();
        RdData = 8'hEE; RdData_Valid = 1;
        step(); step();
        RdData_Valid = 0;
        n_checks++; if (busy !== 1'b0 || rsp_data !== 8'h11 || {p0_ack, p1_ack} !== 2'b00) begin n_fail++; $display("FAIL spurious_valid: got busy %b data %h acks %b want 0 11 00", busy, rsp_data, {p0_ack, p1_ack}); end
        $display("txn: spurious valid in idle ignored");
        p1_req = 1; p1_we = 0; p1_addr = 4'd5;
        for (int k = 1; k <= TO + 1; k++) step();
        n_checks++; if (p1_ack !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL edge_wait: got ack %b busy %b want 0 1", p1_ack, busy); end
        RdData = 8'h77; RdData_Valid = 1;
        step();
        RdData_Valid = 0; RdData = 8'h00;
        n_checks++; if (p1_ack !== 1'b1 || rsp_data !== 8'h77 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL edge_capture: got ack %b %h err %b want 1 77 0", p1_ack, rsp_data, rsp_err); end
        p1_req = 0;
        step();
        $display("txn: p1 read addr 5 valid on timeout cycle -> 77");
    endtask

    task automatic test_back_to_back();
        int order[8];
        int at[8];
        int n = 0;
        int clash = 0;
        rst = 1; step(); rst = 0;
        p0_req = 1; p0_we = 1; p0_addr = 4'd1; p0_wdata = 8'hA0;
        p1_req = 1; p1_we = 1; p1_addr = 4'd2; p1_wdata = 8'hB0;
        for (int k = 1; k <= 60 && n < 8; k++) begin
            step();
            if ((WrEn && RdEn) || (p0_ack && p1_ack)) clash++;
            if (p0_ack) begin order[n] = 0; at[n] = k; n++; end
            else if (p1_ack) begin order[n] = 1; at[n] = k; n++; end
        end
        p0_req = 0; p1_req = 0;
        step();
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d acks want 8", n); end
        n_checks++; if (clash !== 0) begin n_fail++; $display("FAIL b2b_exclusive: got %0d clash cycles want 0", clash); end
        for (int i = 0; i < n; i++) begin
            $display("txn: back-to-back grant %0d -> port %0d at cycle %0d", i, order[i], at[i]);
            n_checks++; if (order[i] !== i % 2) begin n_fail++; $display("FAIL b2b_order[%0d]: got port %0d want %0d", i, order[i], i % 2); end
            if (i > 0) begin
                n_checks++; if (at[i] - at[i-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, at[i] - at[i-1]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        // Serve p0 first so prio points at p1 before the reset.
        p0_req = 1; p0_we = 1; p0_addr = 4'd6; p0_wdata = 8'h3C;
        step(); step();
        p0_req = 0;
        step();
        p0_req = 1; p0_we = 0; p0_addr = 4'd8;
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_inwait: got busy %b want 1", busy); end
        rst = 1;
        #1;
        n_checks++; if ({WrEn, RdEn, p0_ack, p1_ack, rsp_err, busy} !== 6'b0 || Address !== '0 || Wr_D !== '0 || rsp_data !== '0) begin n_fail++; $display("FAIL mid_reset_out: got ctl %b addr %h wd %h data %h want all 0", {WrEn, RdEn, p0_ack, p1_ack, rsp_err, busy}, Address, Wr_D, rsp_data); end
        p0_we = 1; p0_addr = 4'd10; p0_wdata = 8'h42;
        p1_req = 1; p1_we = 0; p1_addr = 4'd11;
        step(); step();
        n_checks++; if ({p0_ack, p1_ack, WrEn, RdEn} !== 4'b0) begin n_fail++; $display("FAIL mid_no_ack: got %b want 0000", {p0_ack, p1_ack, WrEn, RdEn}); end
        rst = 0;
        step();
        n_checks++; if ({WrEn, RdEn} !== 2'b10 || Address !== 4'd10) begin n_fail++; $display("FAIL mid_regrant: got WrEn/RdEn %b addr %h want 10 a", {WrEn, RdEn}, Address); end
        step();
        n_checks++; if ({p0_ack, p1_ack} !== 2'b10) begin n_fail++; $display("FAIL mid_ack: got %b want 10", {p0_ack, p1_ack}); end
        p0_req = 0; p1_req = 0;
        step(); step();
        $display("txn: reset during wait, first grant after release to p0");
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_p1();
        test_timeout();
        test_valid_edges();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
